uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Transmit-side UART frame serializer; counterpart to the receive-path input synchronizer.
- Accepts one parallel character over a valid/ready handshake and shifts it out on the serial line as start, data LSB-first, optional parity and stop bits.
- Bit timing comes from the shared baud generator's 16x oversample enable.
- stx_o is a registered, glitch-free output that drives the pad directly.

Parameters:
- Tp, 1: non-blocking assignment delay applied to every register.
- OVERSAMPLE, 16: enable_i ticks per serial bit. Must be a power of 2, range 4 to 16.

Ports:
- clk_i, input, 1: system clock.
- rst_ni, input, 1: asynchronous active-low reset.
- enable_i, input, 1: baud tick at 16x the bit rate, one clk_i cycle wide.
- tx_dat_i, input, 8: character. Bits above the word length are ignored.
- tx_valid_i, input, 1: character offered.
- tx_ready_o, output, 1: serializer can accept a character.
- wlen_i, input, 2: word length. 00 = 5 bits, 01 = 6, 10 = 7, 11 = 8.
- stop2_i, input, 1: 0 = one stop bit, 1 = two stop bits.
- par_en_i, input, 1: parity enable.
- par_even_i, input, 1: 1 = even parity, 0 = odd parity.
- par_stick_i, input, 1: stick parity. Parity bit = ~par_even_i.
- break_i, input, 1: force the line low.
- stx_o, output, 1: serial output. Idle level is 1.
- busy_o, output, 1: a frame is in progress.
- tx_done_o, output, 1: one-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset (rst_ni = 0, asynchronous):
  - State goes to IDLE.
  - stx_o = 1, tx_ready_o = 1, busy_o = 0, tx_done_o = 0.
  - All counters and the shift register are cleared.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- tx_ready_o = 1 only in IDLE. A character is accepted on a clock edge where tx_valid_i and tx_ready_o are both 1.
- On accept:
  - tx_dat_i, wlen_i, stop2_i and the parity controls are latched. Later changes to these inputs do not affect the current frame.
  - The parity bit is computed from the latched data bits only.
  - Next state is START; stx_o = 0 from the following cycle. busy_o = 1.
- Bit timing:
  - tick_cnt counts enable_i pulses within a bit.
  - A bit ends on the enable_i pulse that occurs while tick_cnt = OVERSAMPLE-1; tick_cnt then wraps to 0.
  - The start bit therefore lasts from accept to the 16th enable_i pulse. Every later bit lasts exactly OVERSAMPLE enable_i pulses.
  - enable_i held low freezes the frame. stx_o holds its current value.
- Transitions:
  - START -> DATA.
  - DATA shifts out the LSB each bit. bit_cnt counts up to wlen+4, then moves to PARITY if parity is enabled, else STOP1.
  - PARITY -> STOP1.
  - STOP1 -> STOP2 if stop2 is set, else IDLE.
  - STOP2 -> IDLE.
- Parity bit value:
  - With par_stick: ~par_even.
  - Otherwise: XOR of the data bits XOR ~par_even.
- tx_done_o pulses in the cycle the FSM returns to IDLE. tx_ready_o rises in the same cycle, so back-to-back frames have no idle gap.
- break_i = 1 forces stx_o = 0 combinationally through the output register, with a one-cycle delay.
  - The FSM keeps running unchanged.
  - Releasing break_i restores the FSM-driven level on the next cycle.
- tx_valid_i dropping mid-frame has no effect on the frame.
- Reset mid-frame aborts the frame immediately; stx_o = 1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state and parity logic are present, as described above.
- Undefined:
  - par_en_i, par_even_i and par_stick_i remain as ports but are ignored.
  - The PARITY state and parity XOR logic are removed.
  - DATA always proceeds to STOP1.

Decomposition:
- Package uart_tx_pkg holds:
  - the state enum;
  - WLEN_5, WLEN_6, WLEN_7, WLEN_8 encodings;
  - the default OVERSAMPLE value.
- One sub-module, uart_tx_bit_timer: tick_cnt with enable_i input, producing a one-cycle bit_end strobe and taking a restart input on accept.
- The FSM and shift register stay in the top module.

Test Plan:
- 8N1, enable_i = 1 every cycle, send 0x55:
  - stx_o = 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles.
  - tx_done_o pulses 160 cycles after accept; busy_o is high for those 160 cycles.
- 5 bits, even parity, 2 stop bits, send 0xFF:
  - Frame = 0, 11111, parity 1, 1, 1.
  - Bits 6-7 are never driven.
  - Repeat with odd parity: parity bit = 0. Stick parity with par_even_i = 1: parity bit = 0.
- Back-to-back: tx_valid_i held high with 0xA3 then 0x3C.
  - The second start bit begins in the cycle right after tx_done_o.
  - No idle-high bit between frames.
- enable_i pulsing every 4th cycle, send 0x01: each bit lasts 64 cycles. Start bit falls 1 cycle after accept.
- break_i asserted mid-DATA for 40 cycles:
  - stx_o = 0 throughout.
  - After release, stx_o equals the correct data/stop level.
  - tx_done_o timing is unchanged.
- rst_ni low during DATA:
  - stx_o = 1 and tx_ready_o = 1 asynchronously.
  - A new send after release produces a clean full frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit serializer.
// The parity helper is only referenced when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } tx_state_e;

  localparam logic [1:0] WLEN_5 = 2'b00;
  localparam logic [1:0] WLEN_6 = 2'b01;
  localparam logic [1:0] WLEN_7 = 2'b10;
  localparam logic [1:0] WLEN_8 = 2'b11;

  localparam int OVERSAMPLE_DEF = 16;

  // Clears the character bits above the selected word length.
  function automatic logic [7:0] mask_word(input logic [7:0] dat, input logic [1:0] wlen);
    logic [7:0] mask;
    case (wlen)
      WLEN_5:  mask = 8'h1F;
      WLEN_6:  mask = 8'h3F;
      WLEN_7:  mask = 8'h7F;
      WLEN_8:  mask = 8'hFF;
      default: mask = 8'hFF;
    endcase
    return dat & mask;
  endfunction

  function automatic logic calc_parity(input logic [7:0] dat, input logic [1:0] wlen,
                                       input logic even, input logic stick);
    logic par;
    if (stick) begin
      par = ~even;
    end else begin
      par = (^mask_word(dat, wlen)) ^ ~even;
    end
    return par;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Counts baud enable ticks inside one serial bit and strobes bit_end_o on the
// tick that closes the bit. restart_i holds the count at zero.
module uart_tx_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic restart_i,
  output logic bit_end_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;

  // Power-of-two OVERSAMPLE lets the counter wrap naturally at the bit end.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (restart_i) begin
      tick_cnt_d = '0;
    end else if (enable_i) begin
      tick_cnt_d = tick_cnt_q + TICK_ONE;
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign bit_end_o = enable_i & ~restart_i & (tick_cnt_q == TICK_LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, LSB-first data, optional parity, stop bits.
// Define UART_TX_PARITY_EN to build the parity bit; otherwise parity ports are ignored.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int Tp         = 1,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic [7:0] tx_dat_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic [1:0] wlen_i,
  input  logic       stop2_i,
  input  logic       par_en_i,
  input  logic       par_even_i,
  input  logic       par_stick_i,
  input  logic       break_i,
  output logic       stx_o,
  output logic       busy_o,
  output logic       tx_done_o
);

  if ((OVERSAMPLE < 4) || (OVERSAMPLE > 16) ||
      ((OVERSAMPLE & (OVERSAMPLE - 1)) != 0) || (Tp < 0)) begin : g_param_check
    $error("uart_tx_serializer: OVERSAMPLE must be a power of 2 in 4..16, Tp >= 0");
  end

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] wlen_q, wlen_d;
  logic       stop2_q, stop2_d;
  logic       stx_q, stx_d;
  logic       done_q, done_d;
  logic       bit_end;
  logic       line_lvl;
  logic [2:0] last_bit;

`ifdef UART_TX_PARITY_EN
  logic       par_en_q, par_en_d;
  logic       parity_q, parity_d;
`else
  logic       unused_par;
  assign unused_par = ^{par_en_i, par_even_i, par_stick_i};
`endif

  uart_tx_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (enable_i),
    .restart_i(state_q == ST_IDLE),
    .bit_end_o(bit_end)
  );

  assign last_bit = {1'b0, wlen_q} + 3'd4;

  // Frame sequencing; the character and its format are captured on accept.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    wlen_d    = wlen_q;
    stop2_d   = stop2_q;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_valid_i) begin
          state_d   = ST_START;
          shift_d   = mask_word(tx_dat_i, wlen_i);
          bit_cnt_d = 3'd0;
          wlen_d    = wlen_i;
          stop2_d   = stop2_i;
`ifdef UART_TX_PARITY_EN
          par_en_d  = par_en_i;
          parity_d  = calc_parity(tx_dat_i, wlen_i, par_even_i, par_stick_i);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
        else         state_d = ST_START;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == last_bit) begin
            bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) state_d = ST_PARITY;
            else          state_d = ST_STOP1;
`else
            state_d = ST_STOP1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP1;
        else         state_d = ST_PARITY;
      end
`endif
      ST_STOP1: begin
        if (bit_end) state_d = stop2_q ? ST_STOP2 : ST_IDLE;
        else         state_d = ST_STOP1;
      end
      ST_STOP2: begin
        if (bit_end) state_d = ST_IDLE;
        else         state_d = ST_STOP2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the next state so stx_o changes with the state register.
  always_comb begin
    line_lvl = 1'b1;
    case (state_d)
      ST_START:  line_lvl = 1'b0;
      ST_DATA:   line_lvl = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line_lvl = parity_d;
`endif
      default:   line_lvl = 1'b1;
    endcase
    if (break_i) stx_d = 1'b0;
    else         stx_d = line_lvl;
    if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) done_d = 1'b1;
    else                                              done_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      wlen_q    <= 2'b00;
      stop2_q   <= 1'b0;
      stx_q     <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      wlen_q    <= wlen_d;
      stop2_q   <= stop2_d;
      stx_q     <= stx_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx_ready_o = (state_q == ST_IDLE);
  assign busy_o     = (state_q != ST_IDLE);
  assign stx_o      = stx_q;
  assign tx_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a frame-level bit-queue model
// checked every cycle, plus hand-computed frame timings and bit values.
module tb_uart_tx_serializer;

  localparam int OS   = 16;
  localparam int LOGN = 8192;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       enable_i = 1'b0;
  logic [7:0] tx_dat_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic [1:0] wlen_i = 2'b11;
  logic       stop2_i = 1'b0;
  logic       par_en_i = 1'b0;
  logic       par_even_i = 1'b0;
  logic       par_stick_i = 1'b0;
  logic       break_i = 1'b0;
  logic       stx_o;
  logic       busy_o;
  logic       tx_done_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int en_mode = 0;
  logic stx_log [LOGN];
  logic busy_log [LOGN];

  uart_tx_serializer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .tx_dat_i(tx_dat_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .wlen_i(wlen_i),
    .stop2_i(stop2_i), .par_en_i(par_en_i), .par_even_i(par_even_i),
    .par_stick_i(par_stick_i), .break_i(break_i), .stx_o(stx_o),
    .busy_o(busy_o), .tx_done_o(tx_done_o)
  );

  initial forever #5 clk_i = ~clk_i;

  function automatic void check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int lg(input int i);
    return (i >= 0 && i < LOGN) ? int'(stx_log[i]) : -1;
  endfunction

  function automatic int bg(input int i);
    return (i >= 0 && i < LOGN) ? int'(busy_log[i]) : -1;
  endfunction

  // Baud enable: every cycle, or one cycle in four.
  initial begin
    int ph = 0;
    forever begin
      @(negedge clk_i);
      case (en_mode)
        0:       enable_i = 1'b1;
        1:       enable_i = (ph % 4 == 0);
        default: enable_i = 1'b0;
      endcase
      ph++;
    end
  end

  // Frame model: a queue of line levels, each held for OS enable pulses.
  initial begin
    bit m_bits[$];
    int m_cnt = 0;
    forever begin
      logic e_stx, e_done, v, en, b, r, s2, pe, pev, pst, x;
      logic [7:0] d;
      logic [1:0] wl;
      int nb;
      @(posedge clk_i);
      cyc++;
      v = tx_valid_i; en = enable_i; b = break_i; r = rst_ni; d = tx_dat_i; wl = wlen_i;
      s2 = stop2_i; pe = par_en_i; pev = par_even_i; pst = par_stick_i;
      e_done = 1'b0;
      if (!r) begin
        m_bits.delete();
        m_cnt = 0;
      end else if (m_bits.size() == 0) begin
        if (v) begin
          nb = int'(wl) + 5;
          m_bits.push_back(1'b0);
          for (int i = 0; i < nb; i++) m_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
          if (pe) begin
            x = 1'b0;
            for (int i = 0; i < nb; i++) x = x ^ d[i];
            m_bits.push_back(pst ? ~pev : (x ^ ~pev));
          end
`endif
          m_bits.push_back(1'b1);
          if (s2) m_bits.push_back(1'b1);
          m_cnt = 0;
        end
      end else if (en) begin
        m_cnt++;
        if (m_cnt == OS) begin
          m_cnt = 0;
          void'(m_bits.pop_front());
          if (m_bits.size() == 0) e_done = 1'b1;
        end
      end
      if (!r)                    e_stx = 1'b1;
      else if (b)                e_stx = 1'b0;
      else if (m_bits.size() > 0) e_stx = m_bits[0];
      else                       e_stx = 1'b1;
      #2;
      check("stx", int'(stx_o), int'(e_stx));
      check("ready", int'(tx_ready_o), (m_bits.size() == 0) ? 1 : 0);
      check("busy", int'(busy_o), (m_bits.size() > 0) ? 1 : 0);
      check("done", int'(tx_done_o), int'(e_done));
      if (cyc < LOGN) begin
        stx_log[cyc] = stx_o;
        busy_log[cyc] = busy_o;
      end
    end
  end

  task automatic offer(input logic [7:0] d, input logic [1:0] wl, input logic s2,
                       input logic pe, input logic pev, input logic pst, output int a);
    @(negedge clk_i);
    check("ready_at_offer", int'(tx_ready_o), 1);
    tx_dat_i = d; wlen_i = wl; stop2_i = s2;
    par_en_i = pe; par_even_i = pev; par_stick_i = pst; tx_valid_i = 1'b1;
    @(posedge clk_i); #3;
    a = cyc;
    @(negedge clk_i);
    tx_valid_i = 1'b0; tx_dat_i = ~d; wlen_i = ~wl; stop2_i = ~s2; par_even_i = ~pev;
  endtask

  task automatic wait_done(input string nm, output int de);
    de = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_i); #3;
      if (tx_done_o === 1'b1) begin
        de = cyc;
        break;
      end
    end
    if (de < 0) begin
      check({nm, "_done_timeout"}, 0, 1);
      de = cyc;
    end
  endtask

  task automatic check_bits(input string nm, input int a, input logic [15:0] bits, input int n);
    for (int k = 0; k < n; k++) check({nm, "_bit"}, lg(a + 8 + OS * k), int'(bits[k]));
  endtask

  task automatic frame(input string nm, input logic [7:0] d, input logic [1:0] wl,
                       input logic s2, input logic pe, input logic pev, input logic pst,
                       input int len, input logic [15:0] bits, input int n);
    int a, de, nbusy;
    offer(d, wl, s2, pe, pev, pst, a);
    wait_done(nm, de);
    check({nm, "_len"}, de - a, len);
    check_bits(nm, a, bits, n);
    nbusy = 0;
    for (int i = a; i < a + len; i++) nbusy += bg(i);
    check({nm, "_busy_cycles"}, nbusy, len);
    check({nm, "_busy_after"}, bg(a + len), 0);
  endtask

  initial begin
    int a, a2, de, de2, s1, run1, run0, zc;
    #12;
    check("reset_stx", int'(stx_o), 1);
    check("reset_ready", int'(tx_ready_o), 1);
    check("reset_busy", int'(busy_o), 0);
    check("reset_done", int'(tx_done_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);

    frame("f8n1_55", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 160, 16'h02AA, 10);
`ifdef UART_TX_PARITY_EN
    frame("f5e2_ff", 8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 144, 16'h01FE, 9);
    frame("f5o2_ff", 8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 144, 16'h01BE, 9);
    frame("f5s2_ff", 8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 144, 16'h01BE, 9);
`else
    frame("f5e2_ff", 8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 128, 16'h00FE, 8);
    frame("f5o2_ff", 8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 128, 16'h00FE, 8);
    frame("f5s2_ff", 8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 128, 16'h00FE, 8);
`endif

    // Back-to-back frames with tx_valid_i held high.
    @(negedge clk_i);
    tx_dat_i = 8'hA3; wlen_i = 2'b11; stop2_i = 1'b0; par_en_i = 1'b0; tx_valid_i = 1'b1;
    @(posedge clk_i); #3;
    a = cyc;
    @(negedge clk_i);
    tx_dat_i = 8'h3C;
    wait_done("b2b_1", de);
    check("b2b_1_len", de - a, 160);
    check_bits("b2b_1", a, 16'h0346, 10);
    @(posedge clk_i); #3;
    a2 = cyc;
    check("b2b_start_after_done", int'(stx_o), 0);
    check("b2b_busy_after_done", int'(busy_o), 1);
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    wait_done("b2b_2", de2);
    check("b2b_2_len", de2 - a2, 160);
    check_bits("b2b_2", a2, 16'h0278, 10);
    repeat (2) @(negedge clk_i);

    // Enable every 4th cycle: each bit is 64 clocks.
    en_mode = 1;
    offer(8'h01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, a);
    wait_done("en4", de);
    check("en4_fall_after_accept", lg(a), 0);
    check("en4_high_before_accept", lg(a - 1), 1);
    s1 = a + 1;
    while (s1 < a + 100 && lg(s1) != 1) s1++;
    check("en4_start_len_in_range", int'((s1 - a >= 61) && (s1 - a <= 64)), 1);
    run1 = 0;
    while (run1 < 200 && lg(s1 + run1) == 1) run1++;
    check("en4_bit0_len", run1, 64);
    run0 = 0;
    while (run0 < 600 && lg(s1 + run1 + run0) == 0) run0++;
    check("en4_zero_bits_len", run0, 448);
    check("en4_done_from_bit0", de - s1, 576);
    en_mode = 0;
    repeat (2) @(negedge clk_i);

    // Break for 40 cycles in the middle of the data bits.
    offer(8'h0F, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, a);
    while (cyc < a + 35) @(negedge clk_i);
    break_i = 1'b1;
    repeat (40) @(negedge clk_i);
    break_i = 1'b0;
    wait_done("brk", de);
    check("brk_len", de - a, 160);
    zc = 0;
    for (int i = a + 36; i <= a + 75; i++) zc += (lg(i) == 0) ? 1 : 0;
    check("brk_low_cycles", zc, 40);
    check("brk_release_level", lg(a + 76), 1);
    check("brk_next_bit_level", lg(a + 80), 0);
    repeat (2) @(negedge clk_i);

    // Asynchronous reset in the middle of DATA, then a clean frame.
    offer(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, a);
    while (cyc < a + 40) @(negedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check("arst_stx", int'(stx_o), 1);
    check("arst_ready", int'(tx_ready_o), 1);
    check("arst_busy", int'(busy_o), 0);
    check("arst_done", int'(tx_done_o), 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    frame("post_rst_a3", 8'hA3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 160, 16'h0346, 10);
    repeat (4) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
